aes_enc: RTL and testbench

Iterative AES-128 encryption core (FIPS-197). It computes one round per clock, with the key expansion done on the fly. A host loads a 128-bit key with `Krdy`, then starts a block with `Drdy`. The ciphertext appears on `Dout` with a one-cycle `Dvld` strobe. It sits beside the sibling `aes_dec` core, which has an identical interface, behind a common bus wrapper.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_enc.sv | 76 +++++++
 tb/tb_aes_enc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants and round transforms shared by aes_enc and aes_dec.
package aes_pkg;

    localparam logic [3:0] NR        = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 4*c+r sits at bits [127-8*(4*c+r) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = SBOX[a];

endmodule

// File: rtl/aes_enc.sv
// aes_enc: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
module aes_enc
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] Din,
    input  logic [127:0] Key,
    input  logic         Drdy,
    input  logic         Krdy,
    input  logic         EN,
    output logic [127:0] Dout,
    output logic         BSY,
    output logic         Dvld
);

    logic [127:0] k0, st, rk, rk_nxt, sb_out, sr_out, rnd_out;
    logic [31:0]  w3_sub, temp, n0, n1, n2, n3;
    logic [7:0]   rcon;
    logic [3:0]   cnt;

    for (genvar i = 0; i < 16; i++) begin : g_st
        aes_sbox u_sbox (.a(st[127-8*i -: 8]), .y(sb_out[127-8*i -: 8]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_ks
        aes_sbox u_sbox (.a(rk[8*i +: 8]), .y(w3_sub[8*i +: 8]));
    end

    // SubWord is bytewise, so rotating after substitution equals RotWord then SubWord.
    assign temp   = {w3_sub[23:0], w3_sub[31:24]} ^ {rcon, 24'h0};
    assign n0     = rk[127:96] ^ temp;
    assign n1     = rk[95:64] ^ n0;
    assign n2     = rk[63:32] ^ n1;
    assign n3     = rk[31:0] ^ n2;
    assign rk_nxt = {n0, n1, n2, n3};

    assign sr_out  = shift_rows(sb_out);
    assign rnd_out = ((cnt == NR) ? sr_out : mix_columns(sr_out)) ^ rk_nxt;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            k0   <= '0;
            st   <= '0;
            rk   <= '0;
            rcon <= '0;
            cnt  <= '0;
            Dout <= '0;
            BSY  <= 1'b0;
            Dvld <= 1'b0;
        end else if (EN) begin
            Dvld <= 1'b0;
            if (BSY) begin
                st   <= rnd_out;
                rk   <= rk_nxt;
                rcon <= xtime(rcon);
                if (cnt == NR) begin
                    Dout <= rnd_out;
                    Dvld <= 1'b1;
                    BSY  <= 1'b0;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else if (Krdy) begin
                k0 <= Key;
            end else if (Drdy) begin
                st   <= Din ^ k0;
                rk   <= k0;
                rcon <= RCON_INIT;
                cnt  <= 4'd1;
                BSY  <= 1'b1;
            end
        end

endmodule

// File: tb/tb_aes_enc.sv
// tb_aes_enc: randomized and known-answer checks of aes_enc against a byte-level AES model.
module tb_aes_enc;

    logic         CLK = 1'b0;
    logic         RST, EN, Drdy, Krdy;
    logic [127:0] Din, Key, Dout;
    logic         BSY, Dvld;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sbox [256];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] E2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] EZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_enc dut (
        .CLK(CLK), .RST(RST), .Din(Din), .Key(Key), .Drdy(Drdy), .Krdy(Krdy),
        .EN(EN), .Dout(Dout), .BSY(BSY), .Dvld(Dvld)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d >> (8 - n);
        return d[7:0];
    endfunction

    // S-box derived from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc = 8'h01;
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tmp = '{sbox[w[i-3]] ^ rc, sbox[w[i-2]], sbox[w[i-1]], sbox[w[i-4]]};
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = sbox[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    s[4*c+q] = ((r == 10) ? t[4*c+q]
                               : gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03)
                                 ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4]) ^ w[16*r+4*c+q];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic load_key(input logic [127:0] k);
        Key = k; Krdy = 1'b1; EN = 1'b1;
        @(negedge CLK);
        Krdy = 1'b0;
    endtask

    // Starts a block at the current negedge and tracks it to Dvld; EN is dropped for
    // en_len edges starting en_at edges after the start, poke injects strobes while busy.
    task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input int en_at,
                             input int en_len, input bit poke, input string tag);
        int n = 0;
        int busy = 1;
        bit got = 1'b0;
        Din = din; Drdy = 1'b1; EN = 1'b1;
        @(negedge CLK);
        Drdy = 1'b0;
        chk({tag, "_bsy_start"}, 128'(BSY), 128'd1);
        chk({tag, "_dvld_start"}, 128'(Dvld), 128'd0);
        while (!got && n < 40) begin
            EN   = !(n >= en_at && n < en_at + en_len);
            Drdy = poke && n == 2;
            Krdy = poke && n == 5;
            if (poke) begin Din = ~din; Key = ~exp; end
            @(negedge CLK);
            n++;
            if (Dvld) got = 1'b1;
            else if (BSY) busy++;
        end
        EN = 1'b1; Drdy = 1'b0; Krdy = 1'b0;
        chk({tag, "_latency"}, 128'(n), 128'(10 + en_len));
        chk({tag, "_bsy_cycles"}, 128'(busy), 128'(10 + en_len));
        chk({tag, "_dout"}, Dout, exp);
        chk({tag, "_bsy_done"}, 128'(BSY), 128'd0);
    endtask

    initial begin
        logic [127:0] k, p;
        RST = 1'b1; EN = 1'b0; Drdy = 1'b0; Krdy = 1'b0; Din = '0; Key = '0;
        build_sbox();
        repeat (2) @(negedge CLK);
        chk("rst_dout", Dout, '0);
        chk("rst_bsy", 128'(BSY), 128'd0);
        chk("rst_dvld", 128'(Dvld), 128'd0);
        RST = 1'b0;
        @(negedge CLK);

        load_key(K1);
        run_block(P1, E1, 99, 0, 1'b0, "c1");
        @(negedge CLK);
        chk("c1_dvld_clear", 128'(Dvld), 128'd0);
        chk("c1_dout_hold", Dout, E1);

        load_key(K2);
        run_block(P2, E2, 99, 0, 1'b0, "appb");

        load_key('0);
        run_block('0, EZ, 99, 0, 1'b0, "zero");
        run_block('0, EZ, 99, 0, 1'b0, "zero_b2b");

        load_key(K1);
        run_block(P1, E1, 99, 0, 1'b1, "poke");

        Key = K2; Din = P2; Krdy = 1'b1; Drdy = 1'b1;
        @(negedge CLK);
        Krdy = 1'b0; Drdy = 1'b0;
        chk("both_no_start", 128'(BSY), 128'd0);
        repeat (11) @(negedge CLK);
        chk("both_no_dvld", 128'(Dvld), 128'd0);
        chk("both_dout_hold", Dout, E1);
        run_block(P2, E2, 99, 0, 1'b0, "both_key");

        EN = 1'b0; Drdy = 1'b1; Krdy = 1'b0;
        repeat (2) @(negedge CLK);
        chk("en0_no_bsy", 128'(BSY), 128'd0);
        Drdy = 1'b0; Krdy = 1'b1; Key = K1;
        @(negedge CLK);
        Krdy = 1'b0; EN = 1'b1;
        run_block(P2, E2, 99, 0, 1'b0, "en0_key_kept");

        run_block(P2, E2, 3, 3, 1'b0, "freeze");

        load_key(K1);
        Din = P1; Drdy = 1'b1;
        @(negedge CLK);
        Drdy = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rstmid_bsy", 128'(BSY), 128'd0);
        chk("rstmid_dvld", 128'(Dvld), 128'd0);
        chk("rstmid_dout", Dout, '0);
        @(negedge CLK);
        RST = 1'b0;
        run_block(P1, ref_enc('0, P1), 99, 0, 1'b0, "rstmid_k0_clear");
        load_key(K1);
        run_block(P1, E1, 99, 0, 1'b0, "rstmid_reload");

        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            load_key(k);
            run_block(p, ref_enc(k, p), (i % 2) ? 4 : 99, (i % 2) ? i : 0, i == 4, "rand");
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(p, ref_enc(k, p), 99, 0, 1'b0, "rand_b2b");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
